// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-memory arbiter slice:
//   - state_t      : arbiter FSM states (CLEAR sweep, IDLE arbitration, RSP)
//   - NOP_WORD     : instruction word returned on an illegal fetch
//   - IMEM_DEPTH   : default number of 32-bit words in the memory
//   - IMEM_AW      : default word-address width, clog2(IMEM_DEPTH)
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RSP   = 2'd2
  } state_t;

endpackage

// File: rtl/imem_clear_seq.sv
// ---------------------------------------------------------------------------
// imem_clear_seq
//   Word counter for the post-reset zero-fill sweep of the instruction memory.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous, active-high reset (counter returns to word 0)
//     run    in   sweep active; counter advances once per cycle while high
//     count  out  AW   word address being written this cycle
//     done   out  1    pulse in the cycle the last word (DEPTH-1) is written
// ---------------------------------------------------------------------------
module imem_clear_seq
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [AW-1:0] count,
  output logic          done
);

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  logic [AW-1:0] count_reg;

  assign count = count_reg;
  assign done  = run && (count_reg == LAST_WORD);

  // Wrap back to 0 after the last word so a later restart (after another
  // reset) never depends on the counter width matching DEPTH exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (run) begin
      if (done) begin
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
//   Shares a single-port synchronous instruction memory between the CPU fetch
//   port (read) and the program loader port (write). After reset the whole
//   memory is swept with zeros, then requests are arbitrated one per cycle.
//
//   Build option: IMEM_ARB_FAIR_EN
//     undefined : loader has strict priority over fetch on a conflict
//     defined   : a last-grant bit alternates grants on a conflict
//
//   Ports:
//     clk, reset            clock; synchronous active-high reset
//     f_valid/f_addr        fetch request (byte address)
//     f_ready               fetch request accepted this cycle
//     f_rvalid/f_rdata/f_err registered fetch response (1-cycle pulse)
//     l_valid/l_addr/l_wdata loader write request (word address)
//     l_ready               loader write accepted this cycle
//     busy                  high while the clear sweep runs (and in reset)
//     mem_en/mem_we/mem_addr/mem_wdata  memory command (combinational)
//     mem_rdata             memory read data, one cycle after a read
// ---------------------------------------------------------------------------
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_valid,
  input  logic [31:0]   f_addr,
  output logic          f_ready,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_valid,
  input  logic [AW-1:0] l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_ready,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t state_reg;
  state_t state_next;

  // Latched at fetch grant: the response must carry the NOP/error.
  logic err_reg;
  logic err_next;

  logic          f_rvalid_reg;
  logic [31:0]   f_rdata_reg;
  logic          f_err_reg;

  logic          grant_l;
  logic          grant_f;
  logic          f_legal;

  logic [AW-1:0] clr_count;
  logic          clr_done;

`ifdef IMEM_ARB_FAIR_EN
  // 1 = loader was granted last, 0 = fetch was granted last.
  logic last_grant_reg;
`endif

  imem_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk   (clk),
    .reset (reset),
    .run   (state_reg == CLEAR),
    .count (clr_count),
    .done  (clr_done)
  );

  // Word-aligned and inside the memory: upper bits beyond the word index
  // must all be zero.
  assign f_legal = (f_addr[1:0] == 2'b00) && (f_addr[31:AW+2] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

`ifdef IMEM_ARB_FAIR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b0;
    end else if (grant_l) begin
      last_grant_reg <= 1'b1;
    end else if (grant_f) begin
      last_grant_reg <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    grant_l    = 1'b0;
    grant_f    = 1'b0;
    f_ready    = 1'b0;
    l_ready    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_reg)
      CLEAR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_count;
        mem_wdata = '0;
        if (clr_done) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
`ifdef IMEM_ARB_FAIR_EN
        if (l_valid && f_valid) begin
          grant_l = !last_grant_reg;
          grant_f = last_grant_reg;
        end else begin
          grant_l = l_valid;
          grant_f = f_valid;
        end
`else
        grant_l = l_valid;
        grant_f = f_valid && !l_valid;
`endif
        if (grant_l) begin
          l_ready   = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = l_addr;
          mem_wdata = l_wdata;
        end
        if (grant_f) begin
          f_ready    = 1'b1;
          state_next = RSP;
          err_next   = !f_legal;
          // An illegal address never touches the memory.
          if (f_legal) begin
            mem_en   = 1'b1;
            mem_we   = 1'b0;
            mem_addr = f_addr[AW+1:2];
          end
        end
      end

      RSP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = CLEAR;
      end
    endcase

    // While reset is held the state register still shows its old value;
    // keep the memory and both handshakes quiet until the sweep begins.
    if (reset) begin
      grant_l   = 1'b0;
      grant_f   = 1'b0;
      f_ready   = 1'b0;
      l_ready   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Response register: mem_rdata is valid during RSP, so it is captured at
  // the end of RSP and presented the following cycle. A reset during RSP
  // therefore suppresses the response.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_rvalid_reg <= 1'b0;
      f_rdata_reg  <= '0;
      f_err_reg    <= 1'b0;
    end else begin
      f_rvalid_reg <= (state_reg == RSP);
      if (state_reg == RSP) begin
        f_rdata_reg <= err_reg ? NOP_WORD : mem_rdata;
        f_err_reg   <= err_reg;
      end
    end
  end

  assign f_rvalid = f_rvalid_reg;
  assign f_rdata  = f_rdata_reg;
  assign f_err    = f_err_reg;
  assign busy     = reset || (state_reg == CLEAR);

endmodule

// File: tb/tb_imem_arbiter.sv
`timescale 1ns/1ps
module tb_imem_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_valid = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_ready;
  logic          f_rvalid;
  logic [31:0]   f_rdata;
  logic          f_err;
  logic          l_valid = 1'b0;
  logic [AW-1:0] l_addr = '0;
  logic [31:0]   l_wdata = '0;
  logic          l_ready;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  always #5 clk = ~clk;

  imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .l_valid(l_valid), .l_addr(l_addr), .l_wdata(l_wdata), .l_ready(l_ready),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory the arbiter drives.
  logic [31:0] mem_array [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem_array[i] = 32'hDEAD_0000 + i;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; logic [31:0] data; logic err; } rsp_t;
  rsp_t        rsp_q[$];
  logic [31:0] shadow [DEPTH];
  int          sweep_pos = 0;     // words already cleared; DEPTH = sweep finished
  bit          blocked   = 0;     // cycle right after a fetch grant
  bit          last_l    = 0;     // loader was granted most recently

  // Observations used by the directed literal checks.
  int          rv_count = 0;
  int          last_rv_cyc = -1;
  logic [31:0] last_rdata = '0;
  logic        last_err = 1'b0;
  int          busy_fall_cyc = -1;
  logic        busy_prev = 1'b1;

  always @(negedge clk) begin : monitor
    logic          e_fr, e_lr, e_en, e_we, e_busy, e_rv, legal;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    bit            g_l, g_f;
    int            idx;
    rsp_t          r;

    e_fr = 0; e_lr = 0; e_en = 0; e_we = 0; e_busy = 0;
    e_addr = '0; e_wd = '0; g_l = 0; g_f = 0; legal = 0; idx = 0;

    if (reset) begin
      e_busy = 1;
    end else if (sweep_pos < DEPTH) begin
      e_busy = 1; e_en = 1; e_we = 1; e_addr = AW'(sweep_pos); e_wd = 0;
    end else if (!blocked) begin
      g_l = l_valid;
      g_f = f_valid && !l_valid;
`ifdef IMEM_ARB_FAIR_EN
      if (l_valid && f_valid) begin
        g_l = !last_l;
        g_f = last_l;
      end
`endif
      if (g_l) begin
        e_lr = 1; e_en = 1; e_we = 1; e_addr = l_addr; e_wd = l_wdata;
      end
      if (g_f) begin
        e_fr  = 1;
        legal = (f_addr % 4 == 0) && (f_addr < DEPTH * 4);
        idx   = int'(f_addr / 4);
        if (legal) begin
          e_en = 1; e_we = 0; e_addr = AW'(idx);
        end
      end
    end

    check("busy", busy, e_busy);
    check("f_ready", f_ready, e_fr);
    check("l_ready", l_ready, e_lr);
    check("mem_en", mem_en, e_en);
    if (e_en) begin
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wd);
    end

    e_rv = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
    check("f_rvalid", f_rvalid, e_rv);
    if (e_rv) begin
      r = rsp_q.pop_front();
      check("f_rdata", f_rdata, r.data);
      check("f_err", f_err, r.err);
    end

    if (f_rvalid) begin
      rv_count++; last_rv_cyc = cyc; last_rdata = f_rdata; last_err = f_err;
    end
    if (busy_prev && !busy) busy_fall_cyc = cyc;
    busy_prev = busy;

    // advance the model to the next cycle
    if (reset) begin
      sweep_pos = 0; blocked = 0; last_l = 0;
      rsp_q.delete();
    end else if (sweep_pos < DEPTH) begin
      shadow[sweep_pos] = 32'h0;
      sweep_pos++;
    end else begin
      blocked = g_f;
      if (g_l) begin
        shadow[l_addr] = l_wdata;
        last_l = 1;
      end
      if (g_f) begin
        last_l = 0;
        r.due  = cyc + 2;
        r.data = legal ? shadow[idx] : 32'h0;
        r.err  = !legal;
        rsp_q.push_back(r);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fetch_one(input logic [31:0] a, output int gcyc, output logic en_at_grant);
    f_addr = a; f_valid = 1; gcyc = -1; en_at_grant = 1'bx;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (f_ready) begin
        gcyc = cyc; en_at_grant = mem_en;
        break;
      end
    end
    tick();
    f_valid = 0;
    check("fetch_granted", 32'(gcyc >= 0), 1);
  endtask

  task automatic load_one(input logic [AW-1:0] a, input logic [31:0] d);
    int gcyc;
    l_addr = a; l_wdata = d; l_valid = 1; gcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (l_ready) begin gcyc = cyc; break; end
    end
    tick();
    l_valid = 0;
    check("load_granted", 32'(gcyc >= 0), 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return ($urandom_range(0, DEPTH - 1) * 4) | $urandom_range(1, 3);
    if (sel == 1) return $urandom | 32'h0000_0100;
    return $urandom_range(0, DEPTH - 1) * 4;
  endfunction

  initial begin : driver
    int          rst_rel, g, gl, rvc, fcnt, lcnt, k, rcount;
    int          gc [3];
    logic        en;
    logic [31:0] words [3];
    bit          fd, ld;

    words[0] = 32'hA000_0001; words[1] = 32'hB000_0002; words[2] = 32'hC000_0003;

    // Reset held: busy high, memory idle, no response.
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_mem_en", mem_en, 0);
    check("rst_f_rvalid", f_rvalid, 0);
    tick();
    reset = 0;
    rst_rel = cyc;

    // Sweep with a loader request pending from the first cycle.
    l_valid = 1; l_addr = 6'd3; l_wdata = 32'h2002_0005;
    @(negedge clk);
    check("sweep_first_addr", mem_addr, 0);
    check("sweep_first_we", mem_we, 1);
    gl = -1;
    if (l_ready) gl = cyc;
    for (int i = 0; i < 100 && gl < 0; i++) begin
      @(negedge clk);
      if (l_ready) gl = cyc;
    end
    tick();
    l_valid = 0;
    check("load_after_sweep", gl - rst_rel, 64);
    check("busy_fall", busy_fall_cyc - rst_rel, 64);

    // Fetch back the loaded word.
    fetch_one(32'h0000_000C, g, en);
    repeat (3) tick();
    check("fetch_latency", last_rv_cyc - g, 2);
    check("fetch_word3", last_rdata, 32'h2002_0005);
    check("fetch_word3_err", last_err, 0);

    // Misaligned and out-of-range fetches.
    fetch_one(32'h0000_000E, g, en);
    repeat (3) tick();
    check("misal_mem_en", en, 0);
    check("misal_err", last_err, 1);
    check("misal_rdata", last_rdata, 0);
    fetch_one(32'h0000_0100, g, en);
    repeat (3) tick();
    check("oor_mem_en", en, 0);
    check("oor_err", last_err, 1);
    check("oor_rdata", last_rdata, 0);

    // Both ports requesting for 6 cycles.
    f_addr = 32'h10; f_valid = 1; l_addr = 6'd5; l_wdata = 32'h5555_AAAA; l_valid = 1;
    fcnt = 0; lcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      fcnt += int'(f_ready); lcnt += int'(l_ready);
    end
    tick();
    f_valid = 0; l_valid = 0;
    repeat (3) tick();
`ifdef IMEM_ARB_FAIR_EN
    check("conflict_l_grants", lcnt, 2);
    check("conflict_f_grants", fcnt, 2);
`else
    check("conflict_l_grants", lcnt, 6);
    check("conflict_f_grants", fcnt, 0);
`endif

    // Reset during RSP drops the response and restarts the sweep.
    fetch_one(32'h0000_000C, g, en);
    reset = 1;
    rvc = rv_count;
    tick();
    reset = 0;
    @(negedge clk);
    check("restart_addr", mem_addr, 0);
    check("restart_en", mem_en, 1);
    repeat (3) tick();
    check("dropped_rsp", rv_count - rvc, 0);
    repeat (70) tick();

    // Back-to-back fetches of three freshly loaded words.
    for (int i = 0; i < 3; i++) load_one(AW'(i), words[i]);
    f_addr = 32'h0; f_valid = 1; k = 0; rcount = 0;
    for (int i = 0; i < 40 && rcount < 3; i++) begin
      @(negedge clk);
      if (f_rvalid) begin
        check("b2b_rdata", f_rdata, words[rcount]);
        rcount++;
      end
      fd = f_ready;
      if (fd) begin gc[k] = cyc; k++; end
      tick();
      if (fd) begin
        if (k < 3) f_addr = 32'(k * 4);
        else f_valid = 0;
      end
    end
    f_valid = 0;
    check("b2b_count", rcount, 3);
    check("b2b_gap1", gc[1] - gc[0], 2);
    check("b2b_gap2", gc[2] - gc[1], 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      fd = f_valid && f_ready;
      ld = l_valid && l_ready;
      tick();
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      if (!f_valid || fd) begin
        f_valid = ($urandom_range(0, 2) != 0);
        f_addr  = rand_addr();
      end
      if (!l_valid || ld) begin
        l_valid = ($urandom_range(0, 2) == 0);
        l_addr  = AW'($urandom_range(0, DEPTH - 1));
        l_wdata = $urandom;
      end
    end
    f_valid = 0; l_valid = 0; reset = 0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
